// File: rtl/cnt_pkg.sv
// rtl/cnt_pkg.sv - shared constants for the down-counter/timer
//
// Purpose: state encoding, mode encoding and default width shared by
// cnt_down_timer and its bench.
package cnt_pkg;

  localparam int CNT_WIDTH_DEFAULT = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic MODE_ONESHOT = 1'b0;
  localparam logic MODE_RELOAD  = 1'b1;

endpackage : cnt_pkg

// File: rtl/cnt_down_timer.sv
// rtl/cnt_down_timer.sv - programmable down-counter/timer, one-shot or auto-reload
//
// Purpose: loads a start value, decrements on enabled cycles while running,
// and pulses tc for one cycle on each terminal event.
// Ports:
//   clk      - system clock, rising edge
//   rst      - asynchronous active-high reset
//   load     - capture load_val into cnt and the reload register
//   load_val - value captured on load
//   start    - IDLE -> RUN request
//   stop     - RUN -> IDLE request, cnt holds
//   en       - count enable, pauses when low
//   mode     - 0 one-shot, 1 auto-reload
//   cnt      - current count (registered)
//   busy     - high while running (decoded from state register)
//   tc       - terminal-count pulse (registered)
module cnt_down_timer
  import cnt_pkg::*;
#(
  parameter int WIDTH = CNT_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             start,
  input  logic             stop,
  input  logic             en,
  input  logic             mode,
  output logic [WIDTH-1:0] cnt,
  output logic             busy,
  output logic             tc
);

  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
  localparam logic [WIDTH-1:0] ZERO = '0;

  state_t           state, state_next;
  logic [WIDTH-1:0] reload, reload_next;
  logic [WIDTH-1:0] cnt_next;
  logic             tc_next;

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      cnt    <= ZERO;
      reload <= ZERO;
      tc     <= 1'b0;
    end else begin
      state  <= state_next;
      cnt    <= cnt_next;
      reload <= reload_next;
      tc     <= tc_next;
    end
  end

  // Next-state and datapath update, in edge priority order:
  // load, then stop, then start, then counting.
  always_comb begin
    state_next  = state;
    cnt_next    = cnt;
    reload_next = reload;
    tc_next     = 1'b0;

    if (load) begin
      cnt_next    = load_val;
      reload_next = load_val;
    end

    if (stop) begin
      state_next = ST_IDLE;
    end else if (start && state == ST_IDLE) begin
      state_next = ST_RUN;
    end else if (state == ST_RUN && en && !load) begin
      if (cnt > ONE) begin
        cnt_next = cnt - ONE;
      end else if (cnt == ONE) begin
        cnt_next = ZERO;
        tc_next  = 1'b1;
        if (mode == MODE_ONESHOT) state_next = ST_IDLE;
      end else if (mode == MODE_RELOAD) begin
        // The 0 cycle is the extra step that makes the period N+1; a zero
        // reload value keeps tc asserted every cycle.
        cnt_next = reload;
        tc_next  = (reload == ZERO);
      end else begin
        // One-shot started at 0: terminate on the first enabled edge.
        tc_next    = 1'b1;
        state_next = ST_IDLE;
      end
    end
  end

  // Output decode
  always_comb begin
    busy = (state == ST_RUN);
  end

endmodule : cnt_down_timer

// File: tb/tb_cnt_down_timer.sv
// tb/tb_cnt_down_timer.sv - directed self-checking bench for cnt_down_timer
module tb_cnt_down_timer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       load = 1'b0;
  logic [3:0] load_val = '0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       en = 1'b0;
  logic       mode = 1'b0;
  logic [3:0] cnt;
  logic       busy;
  logic       tc;

  int n_checks = 0;
  int n_fail   = 0;

  cnt_down_timer #(.WIDTH(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .load_val (load_val),
    .start    (start),
    .stop     (stop),
    .en       (en),
    .mode     (mode),
    .cnt      (cnt),
    .busy     (busy),
    .tc       (tc)
  );

  always #10 clk = ~clk;

  // Advance one rising edge and land on the following falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    load = 1'b1; load_val = 4'd5; start = 1'b1; en = 1'b1; mode = 1'b0;
    tick();
    load = 1'b0; start = 1'b0;
    tick();
    #5 rst = 1'b1;
    #1;
    n_checks++;
    if (cnt !== 4'd0 || busy !== 1'b0 || tc !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_async: cnt=%0d busy=%b tc=%b, required cnt=0 busy=0 tc=0", cnt, busy, tc);
    end
    @(negedge clk);
    rst = 1'b0; en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (cnt !== 4'd0 || busy !== 1'b0 || tc !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_hold[%0d]: cnt=%0d busy=%b tc=%b, required cnt=0 busy=0 tc=0", i, cnt, busy, tc);
      end
    end
  endtask

  task automatic test_oneshot();
    logic [3:0] exp_cnt [8] = '{4'd5, 4'd4, 4'd3, 4'd2, 4'd1, 4'd0, 4'd0, 4'd0};
    logic       exp_tc  [8] = '{0, 0, 0, 0, 0, 1, 0, 0};
    logic       exp_bsy [8] = '{1, 1, 1, 1, 1, 0, 0, 0};
    load = 1'b1; load_val = 4'd5; start = 1'b1; en = 1'b1; mode = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      load = 1'b0; start = 1'b0;
      n_checks++;
      if (cnt !== exp_cnt[i] || tc !== exp_tc[i] || busy !== exp_bsy[i]) begin
        n_fail++;
        $display("FAIL oneshot[%0d]: cnt=%0d tc=%b busy=%b, required cnt=%0d tc=%b busy=%b",
                 i, cnt, tc, busy, exp_cnt[i], exp_tc[i], exp_bsy[i]);
      end
    end
  endtask

  task automatic test_reload();
    logic [3:0] exp_cnt [9] = '{4'd3, 4'd2, 4'd1, 4'd0, 4'd3, 4'd2, 4'd1, 4'd0, 4'd3};
    logic       exp_tc  [9] = '{0, 0, 0, 1, 0, 0, 0, 1, 0};
    load = 1'b1; load_val = 4'd3; start = 1'b1; en = 1'b1; mode = 1'b1;
    for (int i = 0; i < 9; i++) begin
      tick();
      load = 1'b0; start = 1'b0;
      n_checks++;
      if (cnt !== exp_cnt[i] || tc !== exp_tc[i] || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL reload[%0d]: cnt=%0d tc=%b busy=%b, required cnt=%0d tc=%b busy=1",
                 i, cnt, tc, busy, exp_cnt[i], exp_tc[i]);
      end
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    n_checks++;
    if (cnt !== 4'd3 || busy !== 1'b0 || tc !== 1'b0) begin
      n_fail++;
      $display("FAIL reload_stop: cnt=%0d busy=%b tc=%b, required cnt=3 busy=0 tc=0", cnt, busy, tc);
    end
  endtask

  task automatic test_pause();
    logic [3:0] exp_cnt [8] = '{4'd4, 4'd3, 4'd2, 4'd2, 4'd2, 4'd2, 4'd1, 4'd0};
    logic       exp_en  [8] = '{1, 1, 0, 0, 0, 1, 1, 1};
    logic       exp_tc  [8] = '{0, 0, 0, 0, 0, 0, 0, 1};
    logic       exp_bsy [8] = '{1, 1, 1, 1, 1, 1, 1, 0};
    load = 1'b1; load_val = 4'd4; start = 1'b1; en = 1'b1; mode = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      load = 1'b0; start = 1'b0;
      n_checks++;
      if (cnt !== exp_cnt[i] || tc !== exp_tc[i] || busy !== exp_bsy[i]) begin
        n_fail++;
        $display("FAIL pause[%0d]: cnt=%0d tc=%b busy=%b, required cnt=%0d tc=%b busy=%b",
                 i, cnt, tc, busy, exp_cnt[i], exp_tc[i], exp_bsy[i]);
      end
      en = exp_en[i];
    end
    en = 1'b1;
  endtask

  task automatic test_mid_load_and_stop();
    load = 1'b1; load_val = 4'd8; start = 1'b1; en = 1'b1; mode = 1'b0;
    tick();
    load = 1'b0; start = 1'b0;
    tick();
    tick();
    n_checks++;
    if (cnt !== 4'd6 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_pre: cnt=%0d busy=%b, required cnt=6 busy=1", cnt, busy);
    end
    load = 1'b1; load_val = 4'd15;
    tick();
    load = 1'b0;
    n_checks++;
    if (cnt !== 4'd15 || busy !== 1'b1 || tc !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_load: cnt=%0d busy=%b tc=%b, required cnt=15 busy=1 tc=0", cnt, busy, tc);
    end
    tick();
    n_checks++;
    if (cnt !== 4'd14) begin
      n_fail++;
      $display("FAIL mid_load_next: cnt=%0d, required 14", cnt);
    end
    for (int i = 0; i < 5; i++) tick();
    n_checks++;
    if (cnt !== 4'd9 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL stop_pre: cnt=%0d busy=%b, required cnt=9 busy=1", cnt, busy);
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    n_checks++;
    if (cnt !== 4'd9 || busy !== 1'b0 || tc !== 1'b0) begin
      n_fail++;
      $display("FAIL stop: cnt=%0d busy=%b tc=%b, required cnt=9 busy=0 tc=0", cnt, busy, tc);
    end
    tick();
    n_checks++;
    if (cnt !== 4'd9 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL stop_hold: cnt=%0d busy=%b, required cnt=9 busy=0", cnt, busy);
    end
  endtask

  task automatic test_zero_load();
    load = 1'b1; load_val = 4'd0; start = 1'b1; en = 1'b1; mode = 1'b0;
    tick();
    load = 1'b0; start = 1'b0;
    n_checks++;
    if (cnt !== 4'd0 || busy !== 1'b1 || tc !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_oneshot_start: cnt=%0d busy=%b tc=%b, required cnt=0 busy=1 tc=0", cnt, busy, tc);
    end
    tick();
    n_checks++;
    if (cnt !== 4'd0 || busy !== 1'b0 || tc !== 1'b1) begin
      n_fail++;
      $display("FAIL zero_oneshot_tc: cnt=%0d busy=%b tc=%b, required cnt=0 busy=0 tc=1", cnt, busy, tc);
    end
    load = 1'b1; start = 1'b1; mode = 1'b1;
    tick();
    load = 1'b0; start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++;
      if (cnt !== 4'd0 || busy !== 1'b1 || tc !== 1'b1) begin
        n_fail++;
        $display("FAIL zero_reload[%0d]: cnt=%0d busy=%b tc=%b, required cnt=0 busy=1 tc=1", i, cnt, busy, tc);
      end
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  task automatic test_reset_midrun();
    load = 1'b1; load_val = 4'd9; start = 1'b1; en = 1'b1; mode = 1'b0;
    tick();
    load = 1'b0; start = 1'b0;
    tick();
    tick();
    n_checks++;
    if (cnt !== 4'd7 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_mid_pre: cnt=%0d busy=%b, required cnt=7 busy=1", cnt, busy);
    end
    #5 rst = 1'b1;
    #1;
    n_checks++;
    if (cnt !== 4'd0 || busy !== 1'b0 || tc !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid: cnt=%0d busy=%b tc=%b, required cnt=0 busy=0 tc=0", cnt, busy, tc);
    end
    @(negedge clk);
    rst = 1'b0;
    tick();
    n_checks++;
    if (tc !== 1'b0 || busy !== 1'b0 || cnt !== 4'd0) begin
      n_fail++;
      $display("FAIL rst_mid_after: cnt=%0d busy=%b tc=%b, required cnt=0 busy=0 tc=0", cnt, busy, tc);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    n_checks++;
    if (cnt !== 4'd0 || busy !== 1'b1 || tc !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_start: cnt=%0d busy=%b tc=%b, required cnt=0 busy=1 tc=0", cnt, busy, tc);
    end
    tick();
    n_checks++;
    if (cnt !== 4'd0 || busy !== 1'b0 || tc !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_start_tc: cnt=%0d busy=%b tc=%b, required cnt=0 busy=0 tc=1", cnt, busy, tc);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_oneshot();
    test_reload();
    test_pause();
    test_mid_load_and_stop();
    test_zero_load();
    test_reset_midrun();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_cnt_down_timer
